// File: rtl/multiplier_mc_if.sv
// multiplier_mc_if: request and result bundle of the time-shared multiplier.
// master drives requests and observes results; slave is the multiplier itself.
interface multiplier_mc_if #(
    parameter int C_WIDTH    = 32,
    parameter int CH_BITS    = 4,
    parameter int FIFO_DEPTH = 4
);
    logic [C_WIDTH-1:0]          a;
    logic [C_WIDTH-1:0]          b;
    logic                        signed_cal;
    logic [CH_BITS-1:0]          ch_in;
    logic                        trigger;
    logic                        ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        busy;
    logic [C_WIDTH-1:0]          y;
    logic [CH_BITS-1:0]          ch_out;
    logic                        overflow;
    logic                        done;

    modport master (
        output a, b, signed_cal, ch_in, trigger,
        input  ready, fifo_level, busy, y, ch_out, overflow, done
    );

    modport slave (
        input  a, b, signed_cal, ch_in, trigger,
        output ready, fifo_level, busy, y, ch_out, overflow, done
    );
endinterface

// File: rtl/multiplier_mc.sv
// multiplier_mc: queued, channel-tagged radix-2^RADIX_BITS shift-add multiplier with scaling and saturation.
// Optional MUL_ROUND_EN: round half up before the FIXED_POINT shift instead of flooring.
module multiplier_mc #(
    parameter int C_WIDTH     = 32,
    parameter int FIXED_POINT = 0,
    parameter int RADIX_BITS  = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int CH_BITS     = 4
) (
    input  logic           ctl_clk,
    input  logic           reset,
    multiplier_mc_if.slave bus
);
    localparam int N      = C_WIDTH / RADIX_BITS;
    localparam int PW     = 2 * C_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int STEP_W = $clog2(N + 1);
`ifdef MUL_ROUND_EN
    localparam int FP_RND = (FIXED_POINT > 0) ? FIXED_POINT - 1 : 0;
    localparam logic signed [PW:0] ROUND_K =
        (FIXED_POINT > 0) ? ((PW+1)'(1) << FP_RND) : '0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, CALC, FINISH} state_t;

    typedef struct packed {
        logic [C_WIDTH-1:0] a;
        logic [C_WIDTH-1:0] b;
        logic               s;
        logic [CH_BITS-1:0] ch;
    } entry_t;

    function automatic logic [C_WIDTH-1:0] magnitude(input logic [C_WIDTH-1:0] x);
        return x[C_WIDTH-1] ? -x : x;
    endfunction

    // Sign restore, optional rounding and FIXED_POINT shift; unsigned values stay non-negative so >>> floors both modes.
    function automatic logic signed [PW:0] scale_round(input logic [PW-1:0] acc, input logic neg);
        logic signed [PW:0] p;
        p = $signed({1'b0, acc});
        if (neg) p = -p;
`ifdef MUL_ROUND_EN
        p = p + ROUND_K;
`endif
        return p >>> FIXED_POINT;
    endfunction

    // Returns {overflow, y}.
    function automatic logic [C_WIDTH:0] saturate(input logic signed [PW:0] v, input logic sgn);
        logic [PW-C_WIDTH+1:0] hi_s;
        logic [PW-C_WIDTH:0]   hi_u;
        hi_s = v[PW:C_WIDTH-1];
        hi_u = v[PW:C_WIDTH];
        if (sgn) begin
            if ((&hi_s) || !(|hi_s)) return {1'b0, v[C_WIDTH-1:0]};
            return {1'b1, v[PW], {(C_WIDTH-1){~v[PW]}}};
        end
        if (|hi_u) return {1'b1, {C_WIDTH{1'b1}}};
        return {1'b0, v[C_WIDTH-1:0]};
    endfunction

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic [C_WIDTH-1:0] y_q, y_d;
    logic [CH_BITS-1:0] ch_out_q, ch_out_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    entry_t             fifo_mem_q [FIFO_DEPTH];
    entry_t             fifo_mem_d [FIFO_DEPTH];
    entry_t             head;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [C_WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               sgn_q, sgn_d;
    logic [CH_BITS-1:0] ch_q, ch_d;

    logic               ready;
    logic               push;
    logic               pop;

    assign ready = (count_q != LVL_W'(FIFO_DEPTH));
    assign push  = bus.trigger && ready;
    assign head  = fifo_mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        y_d        = y_q;
        ch_out_d   = ch_out_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                step_d  = '0;
                state_d = CALC;
            end
            CALC: begin
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(N - 1)) state_d = FINISH;
            end
            FINISH: begin
                {overflow_d, y_d} = saturate(scale_round(acc_q, neg_q), sgn_q);
                ch_out_d = ch_q;
                done_d   = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + LVL_W'(push) - LVL_W'(pop);
    end

    // Popped operands are parked raw in the shift registers; LOAD converts them to magnitudes.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        neg_d      = neg_q;
        sgn_d      = sgn_q;
        ch_d       = ch_q;
        if (push) fifo_mem_d[wr_ptr_q] = {bus.a, bus.b, bus.signed_cal, bus.ch_in};
        if (pop) begin
            mcand_d  = {{C_WIDTH{1'b0}}, head.a};
            mplier_d = head.b;
            sgn_d    = head.s;
            ch_d     = head.ch;
        end
        case (state_q)
            LOAD: begin
                acc_d = '0;
                if (sgn_q) begin
                    mcand_d  = {{C_WIDTH{1'b0}}, magnitude(mcand_q[C_WIDTH-1:0])};
                    mplier_d = magnitude(mplier_q);
                    neg_d    = mcand_q[C_WIDTH-1] ^ mplier_q[C_WIDTH-1];
                end else begin
                    neg_d = 1'b0;
                end
            end
            CALC: begin
                acc_d    = acc_q + mcand_q * PW'(mplier_q[RADIX_BITS-1:0]);
                mcand_d  = mcand_q << RADIX_BITS;
                mplier_d = mplier_q >> RADIX_BITS;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            step_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            y_q        <= '0;
            ch_out_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            y_q        <= y_d;
            ch_out_q   <= ch_out_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge ctl_clk) begin
        fifo_mem_q <= fifo_mem_d;
        mcand_q    <= mcand_d;
        mplier_q   <= mplier_d;
        acc_q      <= acc_d;
        neg_q      <= neg_d;
        sgn_q      <= sgn_d;
        ch_q       <= ch_d;
    end

    assign bus.ready      = ready;
    assign bus.fifo_level = count_q;
    assign bus.busy       = (state_q != IDLE) || (count_q != '0);
    assign bus.y          = y_q;
    assign bus.ch_out     = ch_out_q;
    assign bus.overflow   = overflow_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_multiplier_mc.sv
// Bench for multiplier_mc: scoreboard queues for a FIXED_POINT=0 instance and a FIXED_POINT=16 instance.
module tb_multiplier_mc;
    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  ch;
        logic        ovf;
    } exp_t;

`ifdef MUL_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    int   done0_cnt  = 0;
    int   done16_cnt = 0;
    int   done0_cycs[$];
    exp_t q0[$];
    exp_t q16[$];

    multiplier_mc_if #(.C_WIDTH(32), .CH_BITS(4), .FIFO_DEPTH(4)) bus0 ();
    multiplier_mc_if #(.C_WIDTH(32), .CH_BITS(4), .FIFO_DEPTH(4)) bus16 ();

    multiplier_mc #(.C_WIDTH(32), .FIXED_POINT(0), .RADIX_BITS(2), .FIFO_DEPTH(4), .CH_BITS(4))
        dut0 (.ctl_clk(clk), .reset(rst_n), .bus(bus0));
    multiplier_mc #(.C_WIDTH(32), .FIXED_POINT(16), .RADIX_BITS(2), .FIFO_DEPTH(4), .CH_BITS(4))
        dut16 (.ctl_clk(clk), .reset(rst_n), .bus(bus16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] y, input logic [3:0] ch, input logic ovf);
        exp_t e;
        e.y = y; e.ch = ch; e.ovf = ovf;
        return e;
    endfunction

    // Reference: direct wide multiply, then round/shift/clamp.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   input logic [3:0] ch, input int fp);
        logic signed [65:0] p;
        exp_t e;
        if (s) p = $signed({{34{a[31]}}, a}) * $signed({{34{b[31]}}, b});
        else   p = $signed({34'd0, a}) * $signed({34'd0, b});
        if (RND && fp > 0) p = p + (66'sd1 <<< (fp - 1));
        p = p >>> fp;
        e.ch = ch; e.ovf = 1'b0; e.y = p[31:0];
        if (s) begin
            if (p > 66'sh7FFFFFFF) begin e.y = 32'h7FFFFFFF; e.ovf = 1'b1; end
            else if (p < -66'sh80000000) begin e.y = 32'h80000000; e.ovf = 1'b1; end
        end else if (p > 66'shFFFFFFFF) begin
            e.y = 32'hFFFFFFFF; e.ovf = 1'b1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus0.done === 1'b1) begin
            done0_cnt++;
            done0_cycs.push_back(cyc);
            checks++;
            if (q0.size() == 0) begin
                $display("FAIL dut0_unexpected_done: got y=%h ch=%0d ovf=%b, required no result",
                         bus0.y, bus0.ch_out, bus0.overflow);
            end else begin
                e = q0.pop_front();
                if ({bus0.y, bus0.ch_out, bus0.overflow} !== e)
                    $display("FAIL dut0_result: got y=%h ch=%0d ovf=%b, required y=%h ch=%0d ovf=%b",
                             bus0.y, bus0.ch_out, bus0.overflow, e.y, e.ch, e.ovf);
                else passes++;
            end
        end
        if (bus16.done === 1'b1) begin
            done16_cnt++;
            checks++;
            if (q16.size() == 0) begin
                $display("FAIL dut16_unexpected_done: got y=%h ch=%0d, required no result",
                         bus16.y, bus16.ch_out);
            end else begin
                e = q16.pop_front();
                if ({bus16.y, bus16.ch_out, bus16.overflow} !== e)
                    $display("FAIL dut16_result: got y=%h ch=%0d ovf=%b, required y=%h ch=%0d ovf=%b",
                             bus16.y, bus16.ch_out, bus16.overflow, e.y, e.ch, e.ovf);
                else passes++;
            end
        end
    end

    // Called at posedge+1; expectation is queued only if the request will be accepted.
    task automatic push0(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [3:0] ch, input exp_t e, output int pcyc);
        bus0.a = a; bus0.b = b; bus0.signed_cal = s; bus0.ch_in = ch; bus0.trigger = 1'b1;
        if (bus0.ready === 1'b1) q0.push_back(e);
        @(posedge clk); #1;
        bus0.trigger = 1'b0;
        bus0.a = $urandom; bus0.b = $urandom; bus0.signed_cal = ~s; bus0.ch_in = ~ch;
        pcyc = cyc;
    endtask

    task automatic push16(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [3:0] ch, input exp_t e);
        bus16.a = a; bus16.b = b; bus16.signed_cal = s; bus16.ch_in = ch; bus16.trigger = 1'b1;
        if (bus16.ready === 1'b1) q16.push_back(e);
        @(posedge clk); #1;
        bus16.trigger = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus0.ready !== 1'b1 || bus0.fifo_level !== 3'd0 || bus0.busy !== 1'b0)
            $display("FAIL reset_ctrl: got ready=%b level=%0d busy=%b, required 1 0 0",
                     bus0.ready, bus0.fifo_level, bus0.busy);
        else passes++;
        checks++;
        if ({bus0.y, bus0.ch_out, bus0.overflow, bus0.done} !== 38'd0)
            $display("FAIL reset_outputs: got y=%h ch=%0d ovf=%b done=%b, required all 0",
                     bus0.y, bus0.ch_out, bus0.overflow, bus0.done);
        else passes++;
        checks++;
        if (bus16.ready !== 1'b1 || bus16.busy !== 1'b0 || bus16.done !== 1'b0)
            $display("FAIL reset_dut16: got ready=%b busy=%b done=%b, required 1 0 0",
                     bus16.ready, bus16.busy, bus16.done);
        else passes++;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_latency();
        int pc, n0, dc;
        n0 = done0_cnt;
        push0(32'h00000071, 32'h000000C2, 1'b0, 4'd3, mk(32'h000055A2, 4'd3, 1'b0), pc);
        for (int i = 0; i < 60 && done0_cnt == n0; i++) @(posedge clk);
        #1;
        checks++;
        if (done0_cnt == n0) begin
            $display("FAIL basic_timeout: got no done in 60 cycles, required one");
        end else begin
            passes++;
            dc = done0_cycs[done0_cycs.size() - 1];
            checks++;
            if (dc - pc !== 19) $display("FAIL basic_latency: got %0d cycles, required 19", dc - pc);
            else passes++;
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus0.y !== 32'h000055A2 || bus0.ch_out !== 4'd3 || bus0.busy !== 1'b0)
            $display("FAIL basic_hold: got y=%h ch=%0d busy=%b, required 000055a2 3 0",
                     bus0.y, bus0.ch_out, bus0.busy);
        else passes++;
    endtask

    task automatic test_saturation();
        int pc;
        push0(32'hEE6C3250, 32'h1BCA53C2, 1'b0, 4'd5, mk(32'hFFFFFFFF, 4'd5, 1'b1), pc);
        push0(32'h00000005, 32'hFFFFFFFD, 1'b1, 4'd6, mk(32'hFFFFFFF1, 4'd6, 1'b0), pc);
        push0(32'h80000000, 32'h80000000, 1'b1, 4'd7, mk(32'h7FFFFFFF, 4'd7, 1'b1), pc);
        push0(32'h80000000, 32'h7FFFFFFF, 1'b1, 4'd8, mk(32'h80000000, 4'd8, 1'b1), pc);
        for (int i = 0; i < 200 && (q0.size() != 0 || bus0.busy !== 1'b0); i++) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0) $display("FAIL saturation_drain: got %0d pending, required 0", q0.size());
        else passes++;
        push0(32'h80000000, 32'h00000001, 1'b1, 4'd9, mk(32'h80000000, 4'd9, 1'b0), pc);
        push0(32'hFFFFFFFF, 32'h00000001, 1'b0, 4'd10, mk(32'hFFFFFFFF, 4'd10, 1'b0), pc);
        for (int i = 0; i < 120 && (q0.size() != 0 || bus0.busy !== 1'b0); i++) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0) $display("FAIL limits_drain: got %0d pending, required 0", q0.size());
        else passes++;
    endtask

    task automatic test_random();
        int pc;
        logic [31:0] a, b;
        logic s;
        for (int k = 0; k < 8; k++) begin
            a = $urandom; b = $urandom; s = k[0];
            if (k == 2) b = b >> 20;
            if (k == 3) a = a >> 24;
            for (int i = 0; i < 40 && bus0.ready !== 1'b1; i++) @(posedge clk);
            #1;
            push0(a, b, s, 4'(k), model(a, b, s, 4'(k), 0), pc);
        end
        for (int i = 0; i < 300 && (q0.size() != 0 || bus0.busy !== 1'b0); i++) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0) $display("FAIL random_drain: got %0d pending, required 0", q0.size());
        else passes++;
    endtask

    task automatic test_fixed_point();
        push16(32'h00018000, 32'h00020000, 1'b1, 4'd1, mk(32'h00030000, 4'd1, 1'b0));
        push16(32'h00000001, 32'h00008000, 1'b1, 4'd2, mk(RND ? 32'd1 : 32'd0, 4'd2, 1'b0));
        push16(32'hFFFFFFFF, 32'h00008000, 1'b1, 4'd3, mk(RND ? 32'd0 : 32'hFFFFFFFF, 4'd3, 1'b0));
        push16(32'h7FFF0000, 32'h00030000, 1'b1, 4'd4, mk(32'h7FFFFFFF, 4'd4, 1'b1));
        for (int i = 0; i < 200 && (q16.size() != 0 || bus16.busy !== 1'b0); i++) @(posedge clk);
        #1;
        checks++;
        if (q16.size() != 0) $display("FAIL fp_drain: got %0d pending, required 0", q16.size());
        else passes++;
    endtask

    task automatic test_back_to_back();
        int pc, base;
        logic [31:0] a, b;
        base = done0_cycs.size();
        push0(32'h00001234, 32'h00000056, 1'b0, 4'd9, mk(32'h00061D78, 4'd9, 1'b0), pc);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus0.busy !== 1'b1 || bus0.fifo_level !== 3'd0)
            $display("FAIL b2b_engine_busy: got busy=%b level=%0d, required 1 0", bus0.busy, bus0.fifo_level);
        else passes++;
        for (int k = 0; k < 5; k++) begin
            a = $urandom; b = $urandom;
            push0(a, b, 1'b1, 4'(k), model(a, b, 1'b1, 4'(k), 0), pc);
            if (k == 3) begin
                checks++;
                if (bus0.ready !== 1'b0 || bus0.fifo_level !== 3'd4)
                    $display("FAIL b2b_full: got ready=%b level=%0d, required 0 4", bus0.ready, bus0.fifo_level);
                else passes++;
            end
        end
        checks++;
        if (bus0.fifo_level !== 3'd4)
            $display("FAIL b2b_ignored_push: got level=%0d, required 4", bus0.fifo_level);
        else passes++;
        for (int i = 0; i < 300 && (q0.size() != 0 || bus0.busy !== 1'b0); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || bus0.busy !== 1'b0 || bus0.ready !== 1'b1)
            $display("FAIL b2b_drain: got pending=%0d busy=%b ready=%b, required 0 0 1",
                     q0.size(), bus0.busy, bus0.ready);
        else passes++;
        checks++;
        if (done0_cycs.size() != base + 5) begin
            $display("FAIL b2b_done_count: got %0d, required 5", done0_cycs.size() - base);
        end else begin
            passes++;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (done0_cycs[base + k + 1] - done0_cycs[base + k] !== 18)
                    $display("FAIL b2b_spacing: got %0d cycles, required 18",
                             done0_cycs[base + k + 1] - done0_cycs[base + k]);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int pc, n0, dc;
        push0(32'h00000003, 32'h00000004, 1'b0, 4'd1, mk(32'd12, 4'd1, 1'b0), pc);
        push0(32'h00000005, 32'h00000006, 1'b0, 4'd2, mk(32'd30, 4'd2, 1'b0), pc);
        push0(32'h00000007, 32'h00000008, 1'b0, 4'd3, mk(32'd56, 4'd3, 1'b0), pc);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus0.fifo_level !== 3'd2 || bus0.busy !== 1'b1)
            $display("FAIL midreset_setup: got level=%0d busy=%b, required 2 1", bus0.fifo_level, bus0.busy);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        q0.delete();
        n0 = done0_cnt;
        checks++;
        if ({bus0.ready, bus0.fifo_level, bus0.busy, bus0.y, bus0.ch_out, bus0.overflow, bus0.done}
                !== {1'b1, 3'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0})
            $display("FAIL midreset_values: got ready=%b level=%0d busy=%b y=%h ch=%0d ovf=%b done=%b, required 1 0 0 0 0 0 0",
                     bus0.ready, bus0.fifo_level, bus0.busy, bus0.y, bus0.ch_out, bus0.overflow, bus0.done);
        else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (done0_cnt != n0 || bus0.busy !== 1'b0)
            $display("FAIL midreset_no_done: got %0d dones busy=%b, required 0 0", done0_cnt - n0, bus0.busy);
        else passes++;
        push0(32'h00000071, 32'h000000C2, 1'b0, 4'd11, mk(32'h000055A2, 4'd11, 1'b0), pc);
        for (int i = 0; i < 60 && done0_cnt == n0; i++) @(posedge clk);
        #1;
        checks++;
        if (done0_cnt == n0) begin
            $display("FAIL midreset_recover: got no done in 60 cycles, required one");
        end else begin
            passes++;
            dc = done0_cycs[done0_cycs.size() - 1];
            checks++;
            if (dc - pc !== 19) $display("FAIL midreset_latency: got %0d cycles, required 19", dc - pc);
            else passes++;
        end
    endtask

    initial begin
        bus0.a = '0; bus0.b = '0; bus0.signed_cal = 1'b0; bus0.ch_in = '0; bus0.trigger = 1'b0;
        bus16.a = '0; bus16.b = '0; bus16.signed_cal = 1'b0; bus16.ch_in = '0; bus16.trigger = 1'b0;
        test_reset();
        test_basic_latency();
        test_saturation();
        test_random();
        test_fixed_point();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(posedge clk);
        checks++;
        if (q0.size() != 0 || q16.size() != 0)
            $display("FAIL final_scoreboard: got %0d/%0d pending, required 0/0", q0.size(), q16.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/multiplier_mc.md
Name: multiplier_mc

Overview:
- Multi-channel, time-shared sequential multiplier for the synthesizer voice datapath.
- Requests (a, b, sign mode, channel tag) are queued in an input FIFO and processed one at a time by a radix-2^RADIX_BITS shift-add engine.
- Each result is scaled by FIXED_POINT, saturated to C_WIDTH, and returned with its channel tag and a one-cycle done strobe.
- Lets several voices share one multiplier without external arbitration.

Parameters:
- C_WIDTH, 32: operand and result width.
- FIXED_POINT, 0: fractional bits; result = full product >> FIXED_POINT (0 .. C_WIDTH-1).
- RADIX_BITS, 2: multiplier bits consumed per CALC cycle; must divide C_WIDTH.
- FIFO_DEPTH, 4: input queue entries; power of 2, >= 2.
- CH_BITS, 4: channel tag width.

Ports:
- ctl_clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- a  in  C_WIDTH  multiplicand.
- b  in  C_WIDTH  multiplier.
- signed_cal  in  1  1 = two's-complement operands, 0 = unsigned.
- ch_in  in  CH_BITS  request tag.
- trigger  in  1  push request when ready=1.
- ready  out  1  FIFO not full.
- fifo_level  out  log2(FIFO_DEPTH)+1  queued entry count.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- y  out  C_WIDTH  scaled, saturated result.
- ch_out  out  CH_BITS  tag of y.
- overflow  out  1  y was saturated; valid with done.
- done  out  1  one-cycle result strobe.

Behaviour:
- Reset values (reset=0, asynchronous): FIFO emptied, FSM=IDLE, fifo_level=0, ready=1, busy=0, y=0, ch_out=0, overflow=0, done=0.
- Reset mid-operation aborts the operation; no done is produced for in-flight or queued requests.
- FIFO push:
  - trigger=1 with ready=1 stores {a, b, signed_cal, ch_in}.
  - trigger=1 with ready=0 is ignored; no state change.
  - Simultaneous push and pop leaves the count unchanged.
  - ready is derived from the registered count only.
- FSM N = C_WIDTH/RADIX_BITS:
  - IDLE: FIFO non-empty -> pop entry, go to LOAD.
  - LOAD: if signed_cal, take magnitudes of a and b (0x80..0 treated as unsigned 2^(C_WIDTH-1)) and store sign = a_msb XOR b_msb; otherwise sign = 0. Clear 2*C_WIDTH-bit accumulator, step counter = 0; go to CALC.
  - CALC: acc += |a| * b_digit << (RADIX_BITS*step), where b_digit is the next RADIX_BITS of |b|, LSB first. After N cycles go to FINISH.
  - FINISH: compute p = sign ? -acc : acc. Scale by shifting p right FIXED_POINT places (arithmetic if signed_cal, logical otherwise; i.e. floor). Saturate to C_WIDTH, register y, ch_out, overflow, and pulse done=1. If FIFO non-empty, pop and go to LOAD; otherwise go to IDLE.
- Saturation:
  - Unsigned: any nonzero bit above C_WIDTH -> y = all ones, overflow=1.
  - Signed: value outside [-2^(C_WIDTH-1), 2^(C_WIDTH-1)-1] -> clamp to the nearest limit, overflow=1.
- Latency: push on edge E0 into an idle, empty block -> done high after edge E0+N+3 (19 cycles at defaults).
- Throughput: back-to-back results every N+2 cycles.
- Outputs y, ch_out and overflow hold their values until the next done.
- Operands are captured at push time; later changes on a, b, signed_cal or ch_in do not affect queued requests.

Optional Feature:
- Macro MUL_ROUND_EN.
- Defined: add 2^(FIXED_POINT-1) to p before the shift (round half up), then saturate. Rounding may itself cause saturation.
- Undefined: floor as above.
- No effect when FIXED_POINT=0.

Test Plan:
- Unsigned, C_WIDTH=32, FP=0: a=0x00000071, b=0x000000C2, ch_in=3 -> y=0x000055A2, ch_out=3, overflow=0; done exactly 19 cycles after the push edge.
- Unsigned: a=0xEE6C3250, b=0x1BCA53C2 -> y=0xFFFFFFFF, overflow=1.
- Signed: a=0x00000005, b=0xFFFFFFFD -> y=0xFFFFFFF1, overflow=0.
- Signed: a=b=0x80000000 -> y=0x7FFFFFFF, overflow=1.
- FP=16, signed: a=0x00018000, b=0x00020000 -> y=0x00030000.
- FP=16, signed: a=0x00000001, b=0x00008000 -> y=0 without MUL_ROUND_EN, y=1 with it.
- Queue: 5 consecutive triggers, tags 0..4 -> ready low after the 4th push, 5th ignored; done for tags 0..3 in order, 18 cycles apart, then busy=0.
- Reset: assert reset mid-CALC with 2 entries queued -> outputs return to reset values, no done follows; a new request afterwards completes normally.
